mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences data-memory accesses (load/store) between the EX stage and the MEM stage register.
//  Runs a req/ack handshake with a variable-latency data memory and stalls the front of the pipeline until the access completes.
//  Drives the MEM stage register inputs: a pass-through for non-memory ops, a bubble while busy, load data on completion.
// PARAMETERS
//  DATA_W       8   data / load-value width
//  ADDR_W       8   memory address width (the ALU result is the address)
//  DEST_W       2   destination register index width
//  TIMEOUT_CYC  15  max cycles in REQ before abort (used only with MEM_ACC_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset (0 = reset)
//  ex_valid       in   1       EX stage holds a valid instruction
//  ex_wb_en       in   1       instruction writes back
//  ex_mem_r_en    in   1       instruction is a load
//  ex_mem_w_en    in   1       instruction is a store
//  ex_alu_res     in   ADDR_W  ALU result / memory address
//  ex_st_val      in   DATA_W  store data
//  ex_dest        in   DEST_W  destination register
//  mem_req        out  1       memory request, held until ack
//  mem_we         out  1       1 = write, 0 = read; valid while mem_req = 1
//  mem_addr       out  ADDR_W  access address, stable while mem_req = 1
//  mem_wdata      out  DATA_W  store data, stable while mem_req = 1
//  mem_ack        in   1       access done; mem_rdata is valid in the same cycle
//  mem_rdata      in   DATA_W  read data
//  stall          out  1       freeze the IF/ID/EX registers
//  memreg_wb_en, memreg_mem_r_en  out  1       to MEM stage register
//  memreg_val_ldr                 out  DATA_W  to MEM stage register
//  memreg_alu_res                 out  ADDR_W  to MEM stage register
//  memreg_dest                    out  DEST_W  to MEM stage register
//  mem_err        out  1       one-cycle access-abort pulse (tied 0 without the macro)
// BEHAVIOUR
//  - States: IDLE, REQ.
//  - Reset: state = IDLE. All latched fields, mem_req, mem_we and mem_err are 0.
//    A reset mid-REQ drops mem_req immediately, and no completion is emitted.
//  - IDLE, no access: ex_valid & !(mem_r_en | mem_w_en).
//    memreg_* = ex_* combinationally, with memreg_wb_en = ex_wb_en & ex_valid, memreg_val_ldr = 0, stall = 0.
//  - IDLE, access: ex_valid & (mem_r_en | mem_w_en).
//    stall = 1 and memreg_* is a bubble (wb_en = 0, mem_r_en = 0).
//    Latch addr, wdata, dest, wb_en, r_en and we = w_en & !r_en; go to REQ.
//  - r_en and w_en both set: the read wins; the store is dropped.
//  - REQ: mem_req = 1 from registered state, so the first req is 1 cycle after accept.
//  - REQ without mem_ack: stall = 1, bubble out.
//  - REQ with mem_ack: stall = 0. memreg_* = latched fields, memreg_val_ldr = mem_rdata (read) or 0 (write).
//    Stores force memreg_wb_en = 0. Next state = IDLE, and mem_req is low for at least 1 cycle.
//  - Minimum access time: 2 cycles (accept + ack in the first REQ cycle).
//  - mem_ack while in IDLE is ignored.
//  - ex_valid = 0 gives a bubble out and stall = 0.
// CONFIGURATION
//  MEM_ACC_TIMEOUT_EN defined: a cycle counter (width clog2(TIMEOUT_CYC+1)) clears on REQ entry.
//    If the count reaches TIMEOUT_CYC without ack: mem_req drops, mem_err pulses 1 cycle, a bubble is emitted, stall = 0, state = IDLE.
//    An ack in the same cycle as the timeout wins (normal completion).
//  MEM_ACC_TIMEOUT_EN undefined: REQ waits indefinitely; mem_err is tied 0 and no counter exists.
// STRUCTURE
//  - Package mem_ctrl_pkg: state enum (IDLE, REQ) and the default DATA_W / ADDR_W / DEST_W constants.
//  - Sub-module mem_acc_timer (counter + expiry flag) is instantiated only under MEM_ACC_TIMEOUT_EN.
//  - The rest is a single FSM plus a latch register bank.
// TESTING
//  1 ALU op: ex_valid=1, wb_en=1, r/w=0, alu_res=0x3C, dest=2.
//    -> same cycle memreg_alu_res=0x3C, wb_en=1, dest=2; stall=0; mem_req never 1.
//  2 Load: addr=0x20, dest=1, ack on the 3rd REQ cycle with rdata=0xA5.
//    -> stall=1 for 3 cycles (accept plus 2 REQ), 0 on the ack cycle.
//    -> ack cycle: memreg_val_ldr=0xA5, mem_r_en=1, wb_en=1, dest=1, alu_res=0x20.
//  3 Store: addr=0x10, data=0x5A, ack on the first REQ cycle.
//    -> mem_we=1, mem_addr=0x10, mem_wdata=0x5A; completion memreg_wb_en=0, mem_r_en=0.
//  4 Load then store back-to-back.
//    -> store accepted the cycle after the load ack; mem_req low exactly 1 cycle between accesses.
//  5 rst=0 during the 2nd REQ cycle.
//    -> mem_req=0 and all outputs 0 immediately; after release, IDLE with no spurious memreg_wb_en.
//  6 (MEM_ACC_TIMEOUT_EN, TIMEOUT_CYC=4) load, no ack.
//    -> mem_req drops after 4 REQ cycles; mem_err=1 for 1 cycle, bubble out, stall=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the data-memory access controller.
package mem_ctrl_pkg;

  // Controller states: waiting for an access, or holding a request to memory.
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEST_W = 2;

endpackage : mem_ctrl_pkg

// File: rtl/mem_acc_timer.sv
// Cycle counter for an outstanding memory request.
// Clears when a request is accepted, counts while the request is held, and
// flags expiry in the TIMEOUT_CYC-th cycle of the request.
// Instantiated by mem_access_ctrl only when MEM_ACC_TIMEOUT_EN is defined.
module mem_acc_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Count completed request cycles; restart on every new request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current cycle is the TIMEOUT_CYC-th one spent waiting.
  assign expired = run && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule : mem_acc_timer

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between EX and the MEM stage register.
// Accepts a load/store from EX, runs a req/ack handshake with a
// variable-latency memory, stalls the front of the pipeline meanwhile and
// emits the completed access (or a pass-through / bubble) to the MEM register.
// Optional build macro: MEM_ACC_TIMEOUT_EN adds a request timeout that aborts
// the access and pulses mem_err.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEST_W      = DEF_DEST_W,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wb_en,
  input  logic              ex_mem_r_en,
  input  logic              ex_mem_w_en,
  input  logic [ADDR_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_st_val,
  input  logic [DEST_W-1:0] ex_dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              memreg_wb_en,
  output logic              memreg_mem_r_en,
  output logic [DATA_W-1:0] memreg_val_ldr,
  output logic [ADDR_W-1:0] memreg_alu_res,
  output logic [DEST_W-1:0] memreg_dest,
  output logic              mem_err
);

  state_t state, state_nxt;

  logic              accept;
  logic              timeout;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DEST_W-1:0] lat_dest;
  logic              lat_wb_en;
  logic              lat_r_en;
  logic              lat_we;

  // A valid load or store seen while idle starts a new access.
  assign accept = (state == IDLE) && ex_valid && (ex_mem_r_en || ex_mem_w_en);

`ifdef MEM_ACC_TIMEOUT_EN
  mem_acc_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (state == REQ),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: enter REQ on accept, leave on ack or timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_ack || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the access fields on accept; they stay stable while mem_req is up.
  // NOTE: this bank is small and drives outputs directly, so it is reset to
  // give defined mem_addr/mem_wdata/mem_we out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_dest  <= '0;
      lat_wb_en <= 1'b0;
      lat_r_en  <= 1'b0;
      lat_we    <= 1'b0;
    end else if (accept) begin
      lat_addr  <= ex_alu_res;
      lat_wdata <= ex_st_val;
      lat_dest  <= ex_dest;
      lat_wb_en <= ex_wb_en;
      lat_r_en  <= ex_mem_r_en;
      // A load with the store bit also set is a load; the store is dropped.
      lat_we    <= ex_mem_w_en && !ex_mem_r_en;
    end
  end

  // Memory-side handshake, driven from registered state only.
  assign mem_req   = (state == REQ);
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_err   = (state == REQ) && !mem_ack && timeout;

  // Output logic: pass-through, bubble with stall, or completed access.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    stall           = 1'b0;
    memreg_wb_en    = 1'b0;
    memreg_mem_r_en = 1'b0;
    memreg_val_ldr  = '0;
    memreg_alu_res  = '0;
    memreg_dest     = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall = 1'b1;
        end else if (ex_valid) begin
          memreg_wb_en    = ex_wb_en;
          memreg_mem_r_en = ex_mem_r_en;
          memreg_alu_res  = ex_alu_res;
          memreg_dest     = ex_dest;
        end
      end
      REQ: begin
        if (mem_ack) begin
          // Stores never write back; loads return the memory data.
          memreg_wb_en    = lat_wb_en && lat_r_en;
          memreg_mem_r_en = lat_r_en;
          memreg_val_ldr  = lat_r_en ? mem_rdata : '0;
          memreg_alu_res  = lat_addr;
          memreg_dest     = lat_dest;
        end else if (!timeout) begin
          stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule : mem_access_ctrl
